// File: rtl/wfg_stim_mem_ctrl.sv
// Stimulus memory reader: fetches words from start..end, scales by gain and streams them out.
// Optional wrap status outputs are enabled by defining WFG_STIM_MEM_CTRL_WRAP_STATUS_EN.
module wfg_stim_mem_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ctrl_en_q_i,
  input  logic [ADDR_W-1:0] start_val_q_i,
  input  logic [ADDR_W-1:0] end_val_q_i,
  input  logic [7:0]        inc_q_i,
  input  logic [16:0]       gain_q_i,
  output logic              mem_csb_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              wfg_axis_tready_i,
  output logic              wfg_axis_tvalid_o,
`ifdef WFG_STIM_MEM_CTRL_WRAP_STATUS_EN
  output logic              wrap_pulse_o,
  output logic [15:0]       wrap_cnt_o,
`endif
  output logic [DATA_W-1:0] wfg_axis_tdata_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LATCH = 2'd2,
    SEND  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;

  logic [ADDR_W:0]   addr_sum;
  logic              wrap;
  logic              handshake;
  logic [DATA_W-1:0] product;

  // One extra bit on the sum so an overflow past the address space still counts as a wrap.
  always_comb begin
    addr_sum  = {1'b0, addr_q} + (ADDR_W+1)'(inc_q_i);
    wrap      = addr_sum > {1'b0, end_val_q_i};
    handshake = (state_q == SEND) && wfg_axis_tready_i;
    product   = mem_rdata_i * DATA_W'(gain_q_i);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_en_q_i) begin
          state_d = FETCH;
          addr_d  = start_val_q_i;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        tdata_d  = product;
        tvalid_d = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (handshake) begin
          tvalid_d = 1'b0;
          addr_d   = wrap ? start_val_q_i : addr_sum[ADDR_W-1:0];
          state_d  = ctrl_en_q_i ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_csb_o  = (state_q != FETCH);
    mem_addr_o = (state_q == FETCH) ? addr_q : '0;
  end

  assign wfg_axis_tvalid_o = tvalid_q;
  assign wfg_axis_tdata_o  = tdata_q;

`ifdef WFG_STIM_MEM_CTRL_WRAP_STATUS_EN
  logic        wrap_pulse_q;
  logic [15:0] wrap_cnt_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
    end else begin
      wrap_pulse_q <= handshake && wrap;
      if (state_q == IDLE && ctrl_en_q_i) begin
        wrap_cnt_q <= '0;
      end else if (handshake && wrap && wrap_cnt_q != '1) begin
        wrap_cnt_q <= wrap_cnt_q + 16'd1;
      end
    end
  end

  assign wrap_pulse_o = wrap_pulse_q;
  assign wrap_cnt_o   = wrap_cnt_q;
`endif

endmodule
